// File: rtl/sync_fifo_param_pkg.sv
// Shared defaults, depth helper and operation encoding for the parametrised FIFO.
package sync_fifo_param_pkg;

  localparam int unsigned FIFO_DATA_W_DEF = 8;
  localparam int unsigned FIFO_ADDR_W_DEF = 3;
  localparam int unsigned FIFO_MARGIN_DEF = 1;

  // Accepted operation in a cycle, encoded as {wr_ok, rd_ok}.
  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_RD   = 2'b01,
    OP_WR   = 2'b10,
    OP_RW   = 2'b11
  } fifo_op_e;

  // Number of words addressed by an addr_w-bit RAM address.
  function automatic int unsigned fifo_depth(input int unsigned addr_w);
    return 32'd1 << addr_w;
  endfunction

endpackage : sync_fifo_param_pkg

// File: rtl/fifo_ram_dp.sv
// Simple dual-port RAM: synchronous write port, synchronous registered read port.
// Ports:
//   clk      rising-edge clock
//   rst_     synchronous active-low reset (clears the read register only)
//   we_i     write enable; waddr_i/wdata_i sampled at the edge
//   re_i     read enable; rdata_o loads mem[raddr_i] at the edge, holds otherwise
// Read-during-write to the same address returns the old word.
module fifo_ram_dp
  import sync_fifo_param_pkg::*;
#(
  parameter int unsigned DATA_W = FIFO_DATA_W_DEF,
  parameter int unsigned ADDR_W = FIFO_ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  localparam int unsigned DEPTH = fifo_depth(ADDR_W);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Storage array; deliberately not reset.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Registered read port; holds its value when no read is issued.
  always_ff @(posedge clk) begin
    if (!rst_) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule : fifo_ram_dp

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO over a simple dual-port RAM.
// Ports:
//   clk, rst_        clock, synchronous active-low reset
//   wr_, rd_         active-low write / read requests
//   data_in          write data, sampled when the write is accepted
//   data_out         registered read data, valid the cycle after the accepting edge
//   full, empty      occupancy == DEPTH / occupancy == 0
//   almost_full      count >= DEPTH-AF_MARGIN
//   almost_empty     count <= AE_MARGIN
//   count            occupancy 0..DEPTH
//   overflow         one-cycle pulse after a rejected write
//   underflow        one-cycle pulse after a rejected read
// Every output comes from a register; nothing is combinational from wr_/rd_.
module sync_fifo_param
  import sync_fifo_param_pkg::*;
#(
  parameter int unsigned DATA_W    = FIFO_DATA_W_DEF,
  parameter int unsigned ADDR_W    = FIFO_ADDR_W_DEF,
  parameter int unsigned AF_MARGIN = FIFO_MARGIN_DEF,
  parameter int unsigned AE_MARGIN = FIFO_MARGIN_DEF
) (
  input  logic              clk,
  input  logic              rst_,
  input  logic              wr_,
  input  logic              rd_,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              underflow
);

  localparam int unsigned DEPTH = fifo_depth(ADDR_W);
  localparam int unsigned CNT_W = ADDR_W + 1;

  localparam logic [CNT_W-1:0] AF_LEVEL = CNT_W'(DEPTH - AF_MARGIN);
  localparam logic [CNT_W-1:0] AE_LEVEL = CNT_W'(AE_MARGIN);

  // Pointers carry one extra wrap bit above the RAM address.
  logic [CNT_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             af_q, af_d;
  logic             ae_q, ae_d;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;

  logic             wr_ok_c;
  logic             rd_ok_c;
  fifo_op_e         op_c;

  // Accept logic, next pointers/count and next registered flags.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = 1'b0;
    udf_d    = 1'b0;

    // A read never falls through a same-cycle write on an empty FIFO.
    rd_ok_c = !rd_ && !empty_q;
    // At full, a write is accepted only alongside a read that frees a slot.
    wr_ok_c = !wr_ && (!full_q || rd_ok_c);
    op_c    = fifo_op_e'({wr_ok_c, rd_ok_c});

    if (wr_ok_c) begin
      wr_ptr_d = wr_ptr_q + CNT_W'(1);
    end
    if (rd_ok_c) begin
      rd_ptr_d = rd_ptr_q + CNT_W'(1);
    end

    case (op_c)
      OP_WR:   count_d = count_q + CNT_W'(1);
      OP_RD:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    full_d  = (wr_ptr_d[ADDR_W] != rd_ptr_d[ADDR_W]) &&
              (wr_ptr_d[ADDR_W-1:0] == rd_ptr_d[ADDR_W-1:0]);
    empty_d = (wr_ptr_d == rd_ptr_d);
    af_d    = (count_d >= AF_LEVEL);
    ae_d    = (count_d <= AE_LEVEL);

    ovf_d = !wr_ && full_q && !rd_ok_c;
    udf_d = !rd_ && empty_q;
  end

  // State and status registers.
  always_ff @(posedge clk) begin
    if (!rst_) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      af_q     <= 1'b0;
      ae_q     <= 1'b1;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      af_q     <= af_d;
      ae_q     <= ae_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  // Reset also blocks the RAM ports so a write coinciding with reset is dropped.
  fifo_ram_dp #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .rst_    (rst_),
    .we_i    (wr_ok_c && rst_),
    .waddr_i (wr_ptr_q[ADDR_W-1:0]),
    .wdata_i (data_in),
    .re_i    (rd_ok_c && rst_),
    .raddr_i (rd_ptr_q[ADDR_W-1:0]),
    .rdata_o (data_out)
  );

  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = af_q;
  assign almost_empty = ae_q;
  assign count        = count_q;
  assign overflow     = ovf_q;
  assign underflow    = udf_q;

endmodule : sync_fifo_param
